// File: rtl/stroke_interpolator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stroke_interpolator_pkg
// Description : Shared colour definitions and small helpers for the stroke
//               interpolator slice.
// Revision    : 1.0 - initial release
// ============================================================================
package stroke_interpolator_pkg;

   // Colour word carried alongside every plotted pixel.
   localparam int COLOR_WIDTH = 4;
   typedef logic [COLOR_WIDTH-1:0] color_t;

   // Colour driven on the pixel bus whenever no pixel is being plotted.
   localparam color_t COLOR_NONE = 4'hF;

   // Larger of two widths, used to size the shared error accumulator.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stroke_interpolator_if.sv
`default_nettype none
// ============================================================================
// Module      : stroke_interpolator_if
// Description : Cursor-in / pixel-out bus of the stroke interpolator.
//               master = cursor source and canvas side, slave = interpolator.
// Revision    : 1.0 - initial release
// ============================================================================
interface stroke_interpolator_if
   import stroke_interpolator_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
);
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);

   logic          enable;
   logic [XW-1:0] cursor_x;
   logic [YW-1:0] cursor_y;
   color_t        input_color;
   logic [XW-1:0] pixel_x;
   logic [YW-1:0] pixel_y;
   color_t        pixel_color;
   logic          pixel_valid;
   logic          busy;

   modport master (
      output enable, cursor_x, cursor_y, input_color,
      input  pixel_x, pixel_y, pixel_color, pixel_valid, busy
   );

   modport slave (
      input  enable, cursor_x, cursor_y, input_color,
      output pixel_x, pixel_y, pixel_color, pixel_valid, busy
   );

endinterface
`default_nettype wire

// File: rtl/bresenham_stepper.sv
`default_nettype none
// ============================================================================
// Module      : bresenham_stepper
// Description : Bresenham line walker. load captures the start/end points,
//               each step advances one point. x/y show the point the next
//               step lands on; done flags that this step reaches the end.
// Revision    : 1.0 - initial release
// ============================================================================
module bresenham_stepper
   import stroke_interpolator_pkg::*;
#(
   parameter int XW = 10,
   parameter int YW = 9
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load,
   input  logic [XW-1:0] x0,
   input  logic [YW-1:0] y0,
   input  logic [XW-1:0] x1,
   input  logic [YW-1:0] y1,
   input  logic          step,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          done
);
   // Two guard bits: one for the sign, one for the doubled error term.
   localparam int EW = max_int(XW, YW) + 2;

   logic [XW-1:0]        r_x;
   logic [YW-1:0]        r_y;
   logic [XW-1:0]        r_x1;
   logic [YW-1:0]        r_y1;
   logic signed [EW-1:0] r_dx;
   logic signed [EW-1:0] r_dy;
   logic signed [EW-1:0] r_err;
   logic                 r_xneg;
   logic                 r_yneg;

   logic signed [EW-1:0] w_x0s;
   logic signed [EW-1:0] w_y0s;
   logic signed [EW-1:0] w_x1s;
   logic signed [EW-1:0] w_y1s;
   logic signed [EW-1:0] w_ddx;
   logic signed [EW-1:0] w_ddy;
   logic signed [EW-1:0] w_adx;
   logic signed [EW-1:0] w_ady;
   logic signed [EW-1:0] w_e2;
   logic signed [EW-1:0] w_err_n;
   logic                 w_xstep;
   logic                 w_ystep;
   logic [XW-1:0]        w_nx;
   logic [YW-1:0]        w_ny;

   assign w_x0s = EW'(x0);
   assign w_y0s = EW'(y0);
   assign w_x1s = EW'(x1);
   assign w_y1s = EW'(y1);
   assign w_ddx = w_x1s - w_x0s;
   assign w_ddy = w_y1s - w_y0s;
   assign w_adx = w_ddx[EW-1] ? -w_ddx : w_ddx;
   assign w_ady = w_ddy[EW-1] ? -w_ddy : w_ddy;

   // Next point and error term from the current Bresenham state.
   always_comb begin
      w_e2    = r_err <<< 1;
      w_xstep = (w_e2 >= r_dy);
      w_ystep = (w_e2 <= r_dx);
      w_err_n = r_err;
      w_nx    = r_x;
      w_ny    = r_y;
      if (w_xstep) begin
         w_err_n = w_err_n + r_dy;
         w_nx    = r_xneg ? (r_x - XW'(1)) : (r_x + XW'(1));
      end
      if (w_ystep) begin
         w_err_n = w_err_n + r_dx;
         w_ny    = r_yneg ? (r_y - YW'(1)) : (r_y + YW'(1));
      end
   end

   assign x    = w_nx;
   assign y    = w_ny;
   assign done = (w_nx == r_x1) && (w_ny == r_y1);

   // Line state: captured on load, advanced one point per step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x    <= '0;
         r_y    <= '0;
         r_x1   <= '0;
         r_y1   <= '0;
         r_dx   <= '0;
         r_dy   <= '0;
         r_err  <= '0;
         r_xneg <= 1'b0;
         r_yneg <= 1'b0;
      end else if (load) begin
         r_x    <= x0;
         r_y    <= y0;
         r_x1   <= x1;
         r_y1   <= y1;
         r_dx   <= w_adx;
         r_dy   <= -w_ady;
         r_err  <= w_adx - w_ady;
         r_xneg <= w_ddx[EW-1];
         r_yneg <= w_ddy[EW-1];
      end else if (step) begin
         r_x   <= w_nx;
         r_y   <= w_ny;
         r_err <= w_err_n;
      end
   end

endmodule
`default_nettype wire

// File: rtl/stroke_interpolator.sv
`default_nettype none
// ============================================================================
// Module      : stroke_interpolator
// Description : Fills the gap between successive cursor samples while the
//               pen is down by walking a Bresenham line from the last
//               plotted point, one canvas pixel per cycle.
//               Build option STROKE_THICK_EN: every point becomes a 2x2
//               brush emitted over up to four consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module stroke_interpolator
   import stroke_interpolator_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic                clk,
   input  logic                reset_n,
   stroke_interpolator_if.slave bus
);
   localparam int            XW    = $clog2(WIDTH);
   localparam int            YW    = $clog2(HEIGHT);
   localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLOT = 2'd1,
      S_LINE = 2'd2
   } state_t;

   state_t        r_state;
   logic          r_anchor_valid;
   logic [XW-1:0] r_ax;
   logic [YW-1:0] r_ay;
   color_t        r_color;
   logic [XW-1:0] r_px;
   logic [YW-1:0] r_py;
   color_t        r_pcolor;
   logic          r_pvalid;
   logic          r_busy;

   logic [XW-1:0] w_cx;
   logic [YW-1:0] w_cy;
   color_t        w_col;
   logic          w_at_anchor;
   logic          w_load;
   logic          w_step;
   logic [XW-1:0] w_sx;
   logic [YW-1:0] w_sy;
   logic          w_done;

   // Cursor is clamped onto the canvas before anything else sees it.
   assign w_cx        = (bus.cursor_x > X_MAX) ? X_MAX : bus.cursor_x;
   assign w_cy        = (bus.cursor_y > Y_MAX) ? Y_MAX : bus.cursor_y;
   assign w_col       = bus.input_color;
   assign w_at_anchor = (w_cx == r_ax) && (w_cy == r_ay);
   assign w_load      = (r_state == S_IDLE) && bus.enable && r_anchor_valid && !w_at_anchor;

`ifdef STROKE_THICK_EN
   // Brush state: base point being expanded and the offsets still to emit
   // ({diag, down, right}); r_last marks the base point as the line end.
   logic [XW-1:0] r_bx;
   logic [YW-1:0] r_by;
   logic [2:0]    r_mask;
   logic          r_last;
   logic [XW-1:0] w_bnx;
   logic [YW-1:0] w_bny;
   logic [2:0]    w_mask_n;

   // Offsets of a 2x2 brush that still land on the canvas.
   function automatic logic [2:0] brush_mask(input logic [XW-1:0] px, input logic [YW-1:0] py);
      logic right;
      logic down;
      right = (px != X_MAX);
      down  = (py != Y_MAX);
      return {right & down, down, right};
   endfunction

   // The line only advances once the current brush has been fully drawn.
   assign w_step = (r_state == S_LINE) && (r_mask == 3'b000) && !r_last;

   // Next brush pixel in (x+1,y), (x,y+1), (x+1,y+1) order.
   always_comb begin
      w_bnx    = r_bx;
      w_bny    = r_by;
      w_mask_n = r_mask;
      if (r_mask[0]) begin
         w_bnx       = r_bx + XW'(1);
         w_mask_n[0] = 1'b0;
      end else if (r_mask[1]) begin
         w_bny       = r_by + YW'(1);
         w_mask_n[1] = 1'b0;
      end else begin
         w_bnx       = r_bx + XW'(1);
         w_bny       = r_by + YW'(1);
         w_mask_n[2] = 1'b0;
      end
   end
`else
   assign w_step = (r_state == S_LINE);
`endif

   bresenham_stepper #(
      .XW (XW),
      .YW (YW)
   ) u_stepper (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (w_load),
      .x0      (r_ax),
      .y0      (r_ay),
      .x1      (w_cx),
      .y1      (w_cy),
      .step    (w_step),
      .x       (w_sx),
      .y       (w_sy),
      .done    (w_done)
   );

   // Stroke FSM with registered pixel outputs; the strobe defaults low each cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_anchor_valid <= 1'b0;
         r_ax           <= '0;
         r_ay           <= '0;
         r_color        <= '0;
         r_px           <= '0;
         r_py           <= '0;
         r_pcolor       <= COLOR_NONE;
         r_pvalid       <= 1'b0;
         r_busy         <= 1'b0;
`ifdef STROKE_THICK_EN
         r_bx           <= '0;
         r_by           <= '0;
         r_mask         <= '0;
         r_last         <= 1'b0;
`endif
      end else begin
         r_pvalid <= 1'b0;
         r_pcolor <= COLOR_NONE;
         case (r_state)
            S_IDLE: begin
               if (!bus.enable) begin
                  // Pen up: the next pen-down starts a fresh stroke.
                  r_anchor_valid <= 1'b0;
               end else if (!r_anchor_valid) begin
                  r_state  <= S_PLOT;
                  r_color  <= w_col;
                  r_px     <= w_cx;
                  r_py     <= w_cy;
                  r_pcolor <= w_col;
                  r_pvalid <= 1'b1;
`ifdef STROKE_THICK_EN
                  r_bx     <= w_cx;
                  r_by     <= w_cy;
                  r_mask   <= brush_mask(w_cx, w_cy);
                  r_busy   <= 1'b1;
`endif
               end else if (!w_at_anchor) begin
                  r_state <= S_LINE;
                  r_color <= w_col;
                  r_busy  <= 1'b1;
`ifdef STROKE_THICK_EN
                  r_mask  <= 3'b000;
                  r_last  <= 1'b0;
`endif
               end
            end
            S_PLOT: begin
`ifdef STROKE_THICK_EN
               if (r_mask != 3'b000) begin
                  r_px     <= w_bnx;
                  r_py     <= w_bny;
                  r_pcolor <= r_color;
                  r_pvalid <= 1'b1;
                  r_mask   <= w_mask_n;
               end else begin
                  r_ax           <= r_bx;
                  r_ay           <= r_by;
                  r_anchor_valid <= 1'b1;
                  r_busy         <= 1'b0;
                  r_state        <= S_IDLE;
               end
`else
               r_ax           <= r_px;
               r_ay           <= r_py;
               r_anchor_valid <= 1'b1;
               r_state        <= S_IDLE;
`endif
            end
            S_LINE: begin
`ifdef STROKE_THICK_EN
               if (r_mask != 3'b000) begin
                  r_px     <= w_bnx;
                  r_py     <= w_bny;
                  r_pcolor <= r_color;
                  r_pvalid <= 1'b1;
                  r_mask   <= w_mask_n;
               end else if (r_last) begin
                  r_ax    <= r_bx;
                  r_ay    <= r_by;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_px     <= w_sx;
                  r_py     <= w_sy;
                  r_pcolor <= r_color;
                  r_pvalid <= 1'b1;
                  r_bx     <= w_sx;
                  r_by     <= w_sy;
                  r_mask   <= brush_mask(w_sx, w_sy);
                  r_last   <= w_done;
               end
`else
               r_px     <= w_sx;
               r_py     <= w_sy;
               r_pcolor <= r_color;
               r_pvalid <= 1'b1;
               if (w_done) begin
                  r_ax    <= w_sx;
                  r_ay    <= w_sy;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
`endif
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pixel_x     = r_px;
   assign bus.pixel_y     = r_py;
   assign bus.pixel_color = r_pcolor;
   assign bus.pixel_valid = r_pvalid;
   assign bus.busy        = r_busy;

endmodule
`default_nettype wire
